// File: rtl/shift_op_sequencer.sv
// Command sequencer for the 4-bit barrel_shifter: splits a shift/rotate amount into passes of <=3.
// Optional macro SEQ_ZERO_FLAG_EN adds a res_zero flag on the result port.
module shift_op_sequencer #(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_select,
    input  logic             cmd_direction,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [3:0]       cmd_data,
    output logic             bs_select,
    output logic             bs_direction,
    output logic [1:0]       bs_shift_value,
    output logic [3:0]       bs_din,
    input  logic [3:0]       bs_dout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             busy
`ifdef SEQ_ZERO_FLAG_EN
    ,
    output logic             res_zero
`endif
);

    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  work;
    logic [AMT_W-1:0]   remaining;
    logic [AMT_W-1:0]   rem_next;

    // Largest pass the shifter supports is 3 positions.
    function automatic logic [1:0] step_of(input logic [AMT_W-1:0] r);
        return (r > AMT_W'(3)) ? 2'd3 : r[1:0];
    endfunction

    // bs_shift_value always holds step_of(remaining) while in RUN.
    assign rem_next = remaining - AMT_W'(bs_shift_value);
    assign bs_din   = work;
    assign res_data = work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            work           <= '0;
            remaining      <= '0;
            bs_select      <= 1'b0;
            bs_direction   <= 1'b0;
            bs_shift_value <= 2'd0;
            cmd_ready      <= 1'b1;
            res_valid      <= 1'b0;
            busy           <= 1'b0;
`ifdef SEQ_ZERO_FLAG_EN
            res_zero       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        bs_select    <= cmd_select;
                        bs_direction <= cmd_direction;
                        work         <= cmd_data;
                        remaining    <= cmd_amount;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (cmd_amount == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
`ifdef SEQ_ZERO_FLAG_EN
                            res_zero  <= (cmd_data == 4'b0000);
`endif
                        end else begin
                            state          <= RUN;
                            bs_shift_value <= step_of(cmd_amount);
                        end
                    end
                end
                RUN: begin
                    work      <= bs_dout;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        state          <= DONE;
                        bs_shift_value <= 2'd0;
                        res_valid      <= 1'b1;
`ifdef SEQ_ZERO_FLAG_EN
                        res_zero       <= (bs_dout == 4'b0000);
`endif
                    end else begin
                        bs_shift_value <= step_of(rem_next);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
`ifdef SEQ_ZERO_FLAG_EN
                        res_zero  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
